// File: rtl/mux41_rr_if.sv
// Channel-side and output-side handshake bundle for the 4:1 round-robin collector.
// The slave modport is the collector; the master modport is whatever drives it.
interface mux41_rr_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] in_a;
  logic [BUS_WIDTH-1:0] in_b;
  logic [BUS_WIDTH-1:0] in_c;
  logic [BUS_WIDTH-1:0] in_d;
  logic [3:0]           in_valid;
  logic [3:0]           in_last;
  logic [3:0]           in_ready;
  logic [BUS_WIDTH-1:0] out;
  logic [1:0]           out_sel;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_a, in_b, in_c, in_d, in_valid, in_last, out_ready,
    output in_ready, out, out_sel, out_last, out_valid
  );

  modport master (
    output in_a, in_b, in_c, in_d, in_valid, in_last, out_ready,
    input  in_ready, out, out_sel, out_last, out_valid
  );
endinterface

// File: rtl/mux41_rr.sv
// Four-to-one round-robin collector: merges four valid/ready channels onto one
// registered, source-tagged output stream, keeping multi-beat frames contiguous.
module mux41_rr #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter logic        UNSEL_LVL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  mux41_rr_if.slave  bus_io
);

  typedef enum logic {ARB, LOCK} state_e;

  state_e               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           lch_q, lch_d;
  logic [BUS_WIDTH-1:0] out_q, out_d;
  logic [1:0]           sel_q, sel_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;

  logic [1:0]           gnt_idx;
  logic                 gnt_vld;
  logic [1:0]           cand;
  logic [BUS_WIDTH-1:0] gnt_data;
  logic                 load_ok;
  logic                 accept;

  // Searching from the farthest candidate back to ptr lets the nearest valid
  // channel overwrite the others, giving first-match priority from ptr.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_idx = lch_q;
    gnt_vld = 1'b0;
    cand    = ptr_q;
    if (state_q == LOCK) begin
      gnt_vld = bus_io.in_valid[lch_q];
    end else begin
      for (int k = 3; k >= 0; k--) begin
        cand = ptr_q + 2'(k);
        if (bus_io.in_valid[cand]) begin
          gnt_idx = cand;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd0:    gnt_data = bus_io.in_a;
      2'd1:    gnt_data = bus_io.in_b;
      2'd2:    gnt_data = bus_io.in_c;
      default: gnt_data = bus_io.in_d;
    endcase
  end

  assign load_ok         = !valid_q || bus_io.out_ready;
  assign accept          = gnt_vld && load_ok && !rst;
  assign bus_io.in_ready = accept ? (4'b0001 << gnt_idx) : 4'b0000;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lch_d   = lch_q;
    out_d   = out_q;
    sel_d   = sel_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (accept) begin
      out_d   = gnt_data;
      sel_d   = gnt_idx;
      last_d  = bus_io.in_last[gnt_idx];
      valid_d = 1'b1;
      if (bus_io.in_last[gnt_idx]) begin
        state_d = ARB;
        ptr_d   = gnt_idx + 2'd1;
      end else begin
        state_d = LOCK;
        lch_d   = gnt_idx;
      end
    end else if (valid_q && bus_io.out_ready) begin
      valid_d = 1'b0;
      out_d   = {BUS_WIDTH{UNSEL_LVL}};
      last_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= 2'd0;
      lch_q   <= 2'd0;
      out_q   <= {BUS_WIDTH{UNSEL_LVL}};
      sel_q   <= 2'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lch_q   <= lch_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus_io.out       = out_q;
  assign bus_io.out_sel   = sel_q;
  assign bus_io.out_last  = last_q;
  assign bus_io.out_valid = valid_q;

endmodule

// File: tb/tb_mux41_rr.sv
// Self-checking bench for mux41_rr: directed scenarios then randomized traffic,
// both checked against a transaction-level model; two instances cover both idle levels.
module tb_mux41_rr;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux41_rr_if #(.BUS_WIDTH(BW)) bus0 ();
  mux41_rr_if #(.BUS_WIDTH(BW)) bus1 ();

  mux41_rr #(.BUS_WIDTH(BW), .UNSEL_LVL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus_io(bus0.slave));
  mux41_rr #(.BUS_WIDTH(BW), .UNSEL_LVL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus_io(bus1.slave));

  assign bus1.in_a      = bus0.in_a;
  assign bus1.in_b      = bus0.in_b;
  assign bus1.in_c      = bus0.in_c;
  assign bus1.in_d      = bus0.in_d;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_last   = bus0.in_last;
  assign bus1.out_ready = bus0.out_ready;

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Source-side view: each channel holds one pending beat until it is taken.
  logic [BW-1:0] src_data  [4];
  logic          src_valid [4];
  logic          src_last  [4];
  logic          out_rdy;

  // Transaction-level model of the collector.
  int            m_ptr;
  int            m_lock;   // -1 when arbitrating freely
  int            m_sel;
  logic          m_valid;
  logic          m_last;
  logic [BW-1:0] m_out0;
  logic [BW-1:0] m_out1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_lock  = -1;
    m_sel   = 0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_out0  = '0;
    m_out1  = '1;
  endtask

  function automatic logic [3:0] exp_ready();
    int g;
    g = -1;
    if (rst) return 4'b0000;
    if (m_valid && !out_rdy) return 4'b0000;
    if (m_lock >= 0) begin
      if (src_valid[m_lock]) g = m_lock;
    end else begin
      for (int k = 0; k < 4; k++)
        if (g < 0 && src_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic apply();
    bus0.in_a      = src_data[0];
    bus0.in_b      = src_data[1];
    bus0.in_c      = src_data[2];
    bus0.in_d      = src_data[3];
    for (int i = 0; i < 4; i++) begin
      bus0.in_valid[i] = src_valid[i];
      bus0.in_last[i]  = src_last[i];
    end
    bus0.out_ready = out_rdy;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out"},       32'(bus0.out),       32'(m_out0));
    check({tag, ".out_hi"},    32'(bus1.out),       32'(m_out1));
    check({tag, ".out_sel"},   32'(bus0.out_sel),   32'(m_sel));
    check({tag, ".out_sel_hi"},32'(bus1.out_sel),   32'(m_sel));
    check({tag, ".out_last"},  32'(bus0.out_last),  32'(m_last));
    check({tag, ".out_valid"}, 32'(bus0.out_valid), 32'(m_valid));
    check({tag, ".valid_hi"},  32'(bus1.out_valid), 32'(m_valid));
  endtask

  // One clock: drive, check the combinational grant, clock, advance model, check outputs.
  task automatic cycle(input string tag, output logic [3:0] rdy);
    logic [3:0] er;
    int g;
    apply();
    #1;
    er  = exp_ready();
    rdy = bus0.in_ready;
    check({tag, ".in_ready"},    32'(bus0.in_ready), 32'(er));
    check({tag, ".in_ready_hi"}, 32'(bus1.in_ready), 32'(er));
    @(posedge clk);
    #1;
    g = -1;
    for (int i = 0; i < 4; i++) if (er[i]) g = i;
    if (g >= 0) begin
      m_out0  = src_data[g];
      m_out1  = src_data[g];
      m_sel   = g;
      m_last  = src_last[g];
      m_valid = 1'b1;
      if (src_last[g]) begin
        m_lock = -1;
        m_ptr  = (g + 1) % 4;
      end else begin
        m_lock = g;
      end
      src_valid[g] = 1'b0;
    end else if (m_valid && out_rdy) begin
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_out0  = '0;
      m_out1  = '1;
    end
    check_outputs(tag);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = 1'b0;
      src_last[i]  = 1'b1;
      src_data[i]  = 8'($urandom);
    end
  endtask

  initial begin
    logic [3:0] rdy;
    int exp_seq [6];

    // Reset with every channel requesting.
    model_reset();
    clear_src();
    for (int i = 0; i < 4; i++) src_valid[i] = 1'b1;
    out_rdy = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready",    32'(bus0.in_ready), 32'h0);
    check("reset.in_ready_hi", 32'(bus1.in_ready), 32'h0);
    check_outputs("reset");
    check("reset.out_ff",      32'(bus1.out),      32'hFF);
    clear_src();
    rst = 1'b0;

    // Single channel c.
    src_data[2] = 8'h5A; src_valid[2] = 1'b1; src_last[2] = 1'b1;
    cycle("single", rdy);
    check("single.rdy",  32'(rdy),           32'h4);
    check("single.data", 32'(bus0.out),      32'h5A);
    check("single.sel",  32'(bus0.out_sel),  32'd2);
    check("single.last", 32'(bus0.out_last), 32'd1);

    // Strict round-robin from reset with all four single-beat channels active.
    pulse_reset();
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) begin
        src_valid[i] = 1'b1; src_last[i] = 1'b1; src_data[i] = 8'(16 * i + n);
      end
      cycle("rr", rdy);
      check("rr.sel", 32'(bus0.out_sel), 32'(n % 4));
    end

    // Backpressure: hold 8'h11 for three cycles, then resume.
    pulse_reset();
    clear_src();
    src_data[0] = 8'h11; src_valid[0] = 1'b1;
    cycle("bp_load", rdy);
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = 1'b1; src_data[i] = 8'(8'hA0 + i);
    end
    out_rdy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle("bp_hold", rdy);
      check("bp_hold.rdy", 32'(rdy),          32'h0);
      check("bp_hold.out", 32'(bus0.out),     32'h11);
      check("bp_hold.sel", 32'(bus0.out_sel), 32'd0);
    end
    out_rdy = 1'b1;
    cycle("bp_resume", rdy);
    check("bp_resume.sel", 32'(bus0.out_sel), 32'd1);

    // Frame lock on b with ptr=1; a, c, d wait, then d wraps ptr to a.
    pulse_reset();
    clear_src();
    src_valid[0] = 1'b1;
    cycle("lock_pre", rdy);
    src_valid[0] = 1'b1; src_valid[2] = 1'b1; src_valid[3] = 1'b1;
    exp_seq = '{1, 1, 1, 2, 3, 0};
    for (int n = 0; n < 6; n++) begin
      if (n < 3) begin
        src_valid[1] = 1'b1; src_last[1] = (n == 2); src_data[1] = 8'(8'hB0 + n);
      end
      cycle("lock", rdy);
      check("lock.sel", 32'(bus0.out_sel), 32'(exp_seq[n]));
    end

    // Locked channel goes idle: others are refused and the output drains.
    clear_src();
    src_valid[2] = 1'b1; src_last[2] = 1'b0;
    cycle("stall_start", rdy);
    src_valid[0] = 1'b1; src_valid[1] = 1'b1; src_valid[3] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      cycle("stall", rdy);
      check("stall.rdy", 32'(rdy), 32'h0);
    end
    check("stall.drained", 32'(bus0.out_valid), 32'd0);
    check("stall.idle_hi", 32'(bus1.out),       32'hFF);
    src_valid[2] = 1'b1; src_last[2] = 1'b1;
    for (int n = 0; n < 4; n++) cycle("stall_end", rdy);

    // Asynchronous reset mid-frame while locked on d.
    clear_src();
    src_valid[3] = 1'b1; src_last[3] = 1'b0;
    cycle("midrst_lock", rdy);
    src_valid[0] = 1'b1; src_valid[3] = 1'b1; src_last[3] = 1'b1;
    apply();
    #2;
    rst = 1'b1;
    #1;
    check("midrst.valid",  32'(bus0.out_valid), 32'd0);
    check("midrst.out",    32'(bus0.out),       32'h00);
    check("midrst.out_hi", 32'(bus1.out),       32'hFF);
    check("midrst.sel",    32'(bus0.out_sel),   32'd0);
    check("midrst.last",   32'(bus0.out_last),  32'd0);
    check("midrst.rdy",    32'(bus0.in_ready),  32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    cycle("midrst_after", rdy);
    check("midrst_after.rdy", 32'(rdy),          32'h1);
    check("midrst_after.sel", 32'(bus0.out_sel), 32'd0);

    // Randomized traffic with random frame lengths and backpressure.
    for (int n = 0; n < 600; n++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!src_valid[i] && $urandom_range(0, 1) == 1) begin
          src_valid[i] = 1'b1;
          src_data[i]  = 8'($urandom);
          src_last[i]  = ($urandom_range(0, 2) == 0);
        end
      end
      cycle("rand", rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
